divider_iterative: RTL and testbench
====================================

# divider_iterative

Parametrised multi-cycle integer divider for the RS5 execute stage, implementing RV32M/RV64M DIV, DIVU, REM and REMU. It generalises the fixed one-bit-per-cycle divider in two ways: operand width and bits retired per cycle are both parameters. Divide-by-zero and signed overflow resolve on a short fast path. An optional last-result cache answers repeated operand pairs in one cycle.

## Interface
- `XLEN`, default 32: operand and result width; must be 32 or 64.
- `BITS_PER_CYCLE`, default 1: quotient bits produced per D_CALC cycle; must be 1, 2 or 4. Elaboration fails unless it divides `XLEN`.
- `clk`  in  1: clock. One clock domain; reset is synchronous and active-high.
- `reset`  in  1: synchronous, active-high.
- `start_i`  in  1: request a division; sampled only when `busy_o`=0.
- `kill_i`  in  1: pipeline flush; aborts any operation.
- `op_i`  in  iType_e: DIV, DIVU, REM or REMU. Other values with `start_i`=1 are ignored.
- `rs1_i`  in  XLEN: dividend.
- `rs2_i`  in  XLEN: divisor.
- `busy_o`  out  XLEN-independent 1: high whenever state is not D_IDLE.
- `done_o`  out  1: one-cycle pulse; `result_o` is valid in that cycle.
- `result_o`  out  XLEN: quotient or remainder, according to the accepted op.

## Operation
- Reset values: state D_IDLE, `busy_o`=0, `done_o`=0, `result_o`=0. Cache valid bit cleared.
- FSM states (div_states_e): D_IDLE, D_INIT, D_CALC, D_SIGN.
- **D_IDLE.** `start_i`=1 with a valid op and `kill_i`=0 latches the operands, op and signedness, then moves to D_INIT. If `kill_i`=1 in the same cycle, kill wins and the request is dropped.
- **D_INIT.** Form absolute values when the op is signed, clear the quotient, and load the remainder register (XLEN+1 bits).
  - Divisor = 0: q = all ones, r = dividend; go to D_SIGN with sign fix-up suppressed.
  - Signed dividend = most-negative and divisor = −1: q = dividend, r = 0; go to D_SIGN with fix-up suppressed.
  - Otherwise go to D_CALC with step counter = XLEN/BITS_PER_CYCLE.
- **D_CALC.** Perform `BITS_PER_CYCLE` chained restoring shift-subtract steps per cycle and decrement the counter. At counter = 1, go to D_SIGN.
- **D_SIGN.** For a signed op:
  - negate q if the operand signs differed;
  - negate r if the dividend was negative.
  Register `result_o` (q for DIV/DIVU, r for REM/REMU), pulse `done_o`, and return to D_IDLE.
- `kill_i` in any state: next state D_IDLE, no `done_o`, cache unchanged.
- `start_i` while `busy_o`=1 is ignored. The requester must hold it until `busy_o` falls.
- `reset` mid-operation: immediate return to reset values.

## Timing
- N = cycle in which `start_i` is accepted; K = XLEN/BITS_PER_CYCLE.
- Normal path: D_INIT at N+1, D_CALC at N+2..N+1+K, D_SIGN at N+2+K. `done_o`=1 at N+3+K (N+35 for 32/1).
- Special path (divide-by-zero or overflow): `done_o` at N+3.
- `busy_o` falls in the same cycle `done_o` rises. A new `start_i` may be accepted in that cycle.
- `result_o` holds its value until the next `done_o`.

## Configuration
- `DIV_RESULT_CACHE_EN` defined:
  - On each normal or special completion, store the operands, signedness, q and r.
  - A later start with equal `rs1_i`, `rs2_i` and signedness (op may differ, e.g. REM after DIV) stays in D_IDLE and pulses `done_o` at N+1 with the selected cached value. `busy_o` stays 0.
  - `reset` invalidates the cache.
- Undefined: no cache storage or comparators; every request takes the full path.

## Structure
- Shared package holds `iType_e` and `div_states_e`, plus a `div_cache_t` packed struct: valid, signed, rs1, rs2, q, r.
- Sub-module `div_step`: one combinational restoring step (remainder in, next dividend bit in; remainder out, quotient bit out). It is instantiated `BITS_PER_CYCLE` times via generate.

## Test plan
- DIVU 100/7, XLEN=32, BITS_PER_CYCLE=1 → `result_o`=14, `done_o` at N+35. REMU with the same operands → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. Both at N+35.
- DIV 0x12345678 / 0 → 0xFFFFFFFF, and REMU with the same operands → 0x12345678; both with `done_o` at N+3. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM → 0, both at N+3.
- DIV started at N, `kill_i` at N+10 → `busy_o`=0 at N+11, no `done_o`. A start at N+11 completes normally.
- BITS_PER_CYCLE=4, DIVU 0xFFFFFFFF / 3 → 0x55555555 at N+11. XLEN=64, BITS_PER_CYCLE=2, DIVU 2^63 / 2 → 2^62 at N+35.
- With `DIV_RESULT_CACHE_EN`: DIV 100/7 then REM 100/7 → 2 at N+1 with `busy_o` low. DIVU 100/7 afterwards misses (signedness differs) and takes full latency. After `reset`, REM 100/7 misses.

Source files
------------

// File: rtl/divider_iterative_pkg.sv
// rtl/divider_iterative_pkg.sv - shared types for the iterative divider
// Holds the operation encoding, FSM state type, result cache record and
// small op-decode helpers used by divider_iterative.
package divider_iterative_pkg;

    // Widest supported operand; cache fields are sized to it.
    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        DIV  = 3'd1,
        DIVU = 3'd2,
        REM  = 3'd3,
        REMU = 3'd4
    } iType_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_INIT,
        D_CALC,
        D_SIGN
    } div_states_e;

    typedef struct packed {
        logic                valid;
        logic                is_signed;
        logic [XLEN_MAX-1:0] rs1;
        logic [XLEN_MAX-1:0] rs2;
        logic [XLEN_MAX-1:0] q;
        logic [XLEN_MAX-1:0] r;
    } div_cache_t;

    function automatic logic op_valid(input iType_e op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

    function automatic logic op_signed(input iType_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_rem(input iType_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract step
// Ports: rem_i (partial remainder), bit_i (next dividend bit), divisor_i,
//        rem_o (updated remainder), q_bit_o (quotient bit produced).
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_bit_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN:0]   diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted[XLEN:0] - {1'b0, divisor_i};
    assign q_bit_o = (shifted >= {2'b00, divisor_i});
    assign rem_o   = q_bit_o ? diff : shifted[XLEN:0];

endmodule

// File: rtl/divider_iterative.sv
// rtl/divider_iterative.sv - multi-cycle DIV/DIVU/REM/REMU unit
// Optional last-result cache: define DIV_RESULT_CACHE_EN.
// Ports: clk, reset (sync, active-high), start_i, kill_i, op_i, rs1_i
//        (dividend), rs2_i (divisor); busy_o (not idle), done_o (one-cycle
//        pulse), result_o (quotient or remainder, held until next done_o).
module divider_iterative
    import divider_iterative_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            kill_i,
    input  iType_e          op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int K     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(K + 1);

    if ((XLEN != 32 && XLEN != 64) || XLEN > XLEN_MAX ||
        (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) ||
        (XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("divider_iterative: unsupported XLEN/BITS_PER_CYCLE");
    end

    div_states_e       state, next_state;
    logic [XLEN-1:0]   rs1_q, rs2_q, divisor_q, q_reg;
    logic [XLEN:0]     rem_reg;
    logic [CNT_W-1:0]  cnt;
    logic              is_signed_q, is_rem_q, neg_q_q, neg_r_q;
    logic              accept, cache_hit, div_zero, overflow, dividend_neg;
    logic [XLEN-1:0]   q_final, r_final;

    assign busy_o = (state != D_IDLE);
    assign accept = (state == D_IDLE) && start_i && !kill_i && op_valid(op_i);

    assign dividend_neg = is_signed_q && rs1_q[XLEN-1];
    assign div_zero     = (rs2_q == '0);
    assign overflow     = is_signed_q && (rs1_q == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_q == '1);

    // Quotient bits shift into q_reg from the right while the dividend bits
    // leave from the left, so q_reg holds the quotient after K cycles.
    logic [XLEN:0]             rem_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_bits;

    assign rem_chain[0] = rem_reg;

    for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem_i     (rem_chain[j]),
            .bit_i     (q_reg[XLEN-1-j]),
            .divisor_i (divisor_q),
            .rem_o     (rem_chain[j+1]),
            .q_bit_o   (q_bits[BITS_PER_CYCLE-1-j])
        );
    end

    assign q_final = neg_q_q ? -q_reg : q_reg;
    assign r_final = neg_r_q ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];

`ifdef DIV_RESULT_CACHE_EN
    div_cache_t cache;

    assign cache_hit = cache.valid &&
                       (cache.is_signed == op_signed(op_i)) &&
                       (cache.rs1 == XLEN_MAX'(rs1_i)) &&
                       (cache.rs2 == XLEN_MAX'(rs2_i));

    always_ff @(posedge clk) begin
        if (reset) begin
            cache <= '0;
        end else if (state == D_SIGN && !kill_i) begin
            cache <= '{valid: 1'b1, is_signed: is_signed_q,
                       rs1: XLEN_MAX'(rs1_q), rs2: XLEN_MAX'(rs2_q),
                       q: XLEN_MAX'(q_final), r: XLEN_MAX'(r_final)};
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= D_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            D_IDLE: if (accept && !cache_hit) next_state = D_INIT;
            D_INIT: next_state = (div_zero || overflow) ? D_SIGN : D_CALC;
            D_CALC: if (cnt == CNT_W'(1)) next_state = D_SIGN;
            D_SIGN: next_state = D_IDLE;
            default: next_state = D_IDLE;
        endcase
        if (kill_i) next_state = D_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            divisor_q   <= '0;
            q_reg       <= '0;
            rem_reg     <= '0;
            cnt         <= '0;
            is_signed_q <= 1'b0;
            is_rem_q    <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            done_o      <= 1'b0;
            result_o    <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                D_IDLE: begin
                    if (accept) begin
                        rs1_q       <= rs1_i;
                        rs2_q       <= rs2_i;
                        is_signed_q <= op_signed(op_i);
                        is_rem_q    <= op_rem(op_i);
`ifdef DIV_RESULT_CACHE_EN
                        if (cache_hit) begin
                            result_o <= op_rem(op_i) ? cache.r[XLEN-1:0] : cache.q[XLEN-1:0];
                            done_o   <= 1'b1;
                        end
`endif
                    end
                end
                D_INIT: begin
                    cnt <= CNT_W'(K);
                    if (div_zero) begin
                        q_reg   <= '1;
                        rem_reg <= {1'b0, rs1_q};
                        neg_q_q <= 1'b0;
                        neg_r_q <= 1'b0;
                    end else if (overflow) begin
                        q_reg   <= rs1_q;
                        rem_reg <= '0;
                        neg_q_q <= 1'b0;
                        neg_r_q <= 1'b0;
                    end else begin
                        q_reg     <= dividend_neg ? -rs1_q : rs1_q;
                        divisor_q <= (is_signed_q && rs2_q[XLEN-1]) ? -rs2_q : rs2_q;
                        rem_reg   <= '0;
                        neg_q_q   <= is_signed_q && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
                        neg_r_q   <= dividend_neg;
                    end
                end
                D_CALC: begin
                    q_reg   <= {q_reg[XLEN-1-BITS_PER_CYCLE:0], q_bits};
                    rem_reg <= rem_chain[BITS_PER_CYCLE];
                    cnt     <= cnt - CNT_W'(1);
                end
                D_SIGN: begin
                    if (!kill_i) begin
                        result_o <= is_rem_q ? r_final : q_final;
                        done_o   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iterative.sv
// tb/tb_divider_iterative.sv - directed self-checking bench for divider_iterative
module tb_divider_iterative;
    import divider_iterative_pkg::*;

`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, kill, start;
    iType_e      op;
    logic [63:0] a, b;
    int          cur;

    logic        start0, start1, start2;
    logic        busy0, busy1, busy2, done0, done1, done2;
    logic [31:0] res0, res1;
    logic [63:0] res2;
    logic        busy_m, done_m;
    logic [63:0] res_m;

    assign start0 = start && (cur == 0);
    assign start1 = start && (cur == 1);
    assign start2 = start && (cur == 2);

    divider_iterative #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .start_i(start0), .kill_i(kill), .op_i(op),
        .rs1_i(a[31:0]), .rs2_i(b[31:0]), .busy_o(busy0), .done_o(done0), .result_o(res0));

    divider_iterative #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .start_i(start1), .kill_i(kill), .op_i(op),
        .rs1_i(a[31:0]), .rs2_i(b[31:0]), .busy_o(busy1), .done_o(done1), .result_o(res1));

    divider_iterative #(.XLEN(64), .BITS_PER_CYCLE(2)) dut64 (
        .clk(clk), .reset(reset), .start_i(start2), .kill_i(kill), .op_i(op),
        .rs1_i(a), .rs2_i(b), .busy_o(busy2), .done_o(done2), .result_o(res2));

    always_comb begin
        busy_m = busy0;
        done_m = done0;
        res_m  = {32'b0, res0};
        case (cur)
            1: begin busy_m = busy1; done_m = done1; res_m = {32'b0, res1}; end
            2: begin busy_m = busy2; done_m = done2; res_m = res2; end
            default: ;
        endcase
    end

    int done0_cnt = 0;
    always @(posedge clk) done0_cnt <= done0_cnt + (done0 ? 1 : 0);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; that cycle is N. Latency is counted in
    // edges until done_o is seen high.
    task automatic run(input int sel, input iType_e o, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] exp, input int exp_lat, input string tag);
        int lat;
        cur   = sel;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!done_m && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_done"}, 64'(done_m), 64'd1);
        chk({tag, "_res"},  res_m, exp);
        chk({tag, "_lat"},  64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(busy_m), 64'd0);
    endtask

    initial begin
        int snap;
        reset = 1'b1; kill = 1'b0; start = 1'b0; op = NOP; a = '0; b = '0; cur = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   64'(busy0), 64'd0);
        chk("rst_done",   64'(done0), 64'd0);
        chk("rst_result", {32'b0, res0}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run(0, DIVU, 64'd100, 64'd7, 64'd14, 35, "divu");
        run(0, REMU, 64'd100, 64'd7, 64'd2, CACHE ? 1 : 35, "remu");
        run(0, DIV,  64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 35, "div_neg");
        run(0, REM,  64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, CACHE ? 1 : 35, "rem_neg");
        run(0, DIV,  64'h12345678, 64'd0, 64'hFFFFFFFF, 3, "div_zero");
        run(0, REMU, 64'h12345678, 64'd0, 64'h12345678, 3, "remu_zero");
        run(0, DIV,  64'h80000000, 64'hFFFFFFFF, 64'h80000000, 3, "div_ovf");
        run(0, REM,  64'h80000000, 64'hFFFFFFFF, 64'd0, CACHE ? 1 : 3, "rem_ovf");

        // invalid op is ignored
        @(posedge clk); #1;
        snap = done0_cnt;
        cur = 0; op = NOP; a = 64'd9; b = 64'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("nop_busy", 64'(busy0), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("nop_nodone", 64'(done0_cnt), 64'(snap));

        // kill mid-calculation, then a fresh start at N+11
        snap = done0_cnt;
        op = DIV; a = 64'd1000; b = 64'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("kill_pre_busy", 64'(busy0), 64'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_busy", 64'(busy0), 64'd0);
        run(0, DIV, 64'd1000, 64'd3, 64'd333, 35, "after_kill");
        @(posedge clk); #1;
        chk("kill_nodone", 64'(done0_cnt), 64'(snap + 1));

        // reset in the middle of an operation
        run(0, DIVU, 64'h0000FFFF, 64'h10, 64'h00000FFF, 35, "pre_rst");
        op = DIVU; a = 64'd50; b = 64'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy",   64'(busy0), 64'd0);
        chk("mid_rst_done",   64'(done0), 64'd0);
        chk("mid_rst_result", {32'b0, res0}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run(1, DIVU, 64'hFFFFFFFF, 64'd3, 64'h55555555, 11, "b4_divu");
        run(1, DIV,  64'hFFFFFF9C, 64'd7, 64'hFFFFFFF2, 11, "b4_div");
        run(2, DIVU, 64'h8000000000000000, 64'd2, 64'h4000000000000000, 35, "x64_divu");
        run(2, REM,  64'hFFFFFFFFFFFFFF9C, 64'd7, 64'hFFFFFFFFFFFFFFFE, 35, "x64_rem");

`ifdef DIV_RESULT_CACHE_EN
        run(0, DIV,  64'd100, 64'd7, 64'd14, 35, "c_div");
        run(0, REM,  64'd100, 64'd7, 64'd2, 1, "c_rem_hit");
        run(0, DIVU, 64'd100, 64'd7, 64'd14, 35, "c_divu_miss");
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run(0, REM,  64'd100, 64'd7, 64'd2, 35, "c_rem_after_rst");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
